// File: rtl/mt_register_file.sv
// Multithreaded integer register file for the barrel-threaded pipeline.
// One block-RAM array of NUM_THREADS banks x NUM_REGS entries x XLEN bits,
// a single write port shared between writeback and a clear engine, and
// NUM_READ_PORTS registered read ports with x0 forcing and write bypass.
//
// Handshake: ready=1 means the clear engine is idle and the write port
// belongs to writeback; a wr_en seen while ready=0 is discarded and
// reported by a one-cycle wr_drop pulse on the following cycle. There is
// no backpressure on reads: rs_en[p] is a plain strobe, answered one
// cycle later on rs_data[p].
module mt_register_file #(
  parameter int NUM_THREADS    = 4,
  parameter int NUM_REGS       = 32,
  parameter int XLEN           = 32,
  parameter int NUM_READ_PORTS = 2,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [TW-1:0]                  wr_thread,
  input  logic [AW-1:0]                  rd_addr,
  input  logic [XLEN-1:0]                new_data,
  input  logic [TW-1:0]                  rs_thread,
  input  logic [NUM_READ_PORTS*AW-1:0]   rs_addr,
  input  logic [NUM_READ_PORTS-1:0]      rs_en,
  output logic [NUM_READ_PORTS*XLEN-1:0] rs_data,
  input  logic                           clear_req,
  input  logic [TW-1:0]                  clear_thread,
  output logic                           ready,
  output logic                           wr_drop
);

  localparam int IW    = TW + AW;
  localparam int DEPTH = NUM_THREADS * NUM_REGS;
  localparam logic [IW-1:0] LAST_ENTRY = IW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_REG   = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    INIT_CLEAR   = 2'd0,
    READY        = 2'd1,
    THREAD_CLEAR = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   cnt, cnt_next;
  logic [TW-1:0]   clr_thread, clr_thread_next;

  // Effective write port (after arbitration between clear engine and writeback).
  logic            we;
  logic [IW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] mem [DEPTH];

  // With a single thread the thread id bit carries no information and is
  // forced to zero so the index never leaves the array.
  function automatic logic [IW-1:0] entry(input logic [TW-1:0] t, input logic [AW-1:0] a);
    if (NUM_THREADS == 1) return {TW'(0), a};
    else                  return {t, a};
  endfunction

  assign ready = (state == READY);

  // FSM state, clear counter and latched flush thread.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_CLEAR;
      cnt        <= '0;
      clr_thread <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      clr_thread <= clr_thread_next;
    end
  end

  // Next-state logic: full-array sweep after reset, per-thread sweep on request.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    clr_thread_next = clr_thread;
    case (state)
      INIT_CLEAR: begin
        if (cnt == LAST_ENTRY) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IW'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_next      = THREAD_CLEAR;
          cnt_next        = '0;
          clr_thread_next = clear_thread;
        end
      end
      THREAD_CLEAR: begin
        if (cnt[AW-1:0] == LAST_REG) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IW'(1);
        end
      end
      default: begin
        state_next = INIT_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // Write-port arbitration: the clear engine wins whenever it is active;
  // writes to x0 are filtered out so x0 never holds anything but zero.
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = '0;
    if (!rst) begin
      case (state)
        INIT_CLEAR: begin
          we    = 1'b1;
          waddr = cnt;
        end
        THREAD_CLEAR: begin
          we    = 1'b1;
          waddr = entry(clr_thread, cnt[AW-1:0]);
        end
        READY: begin
          we    = wr_en && (rd_addr != '0);
          waddr = entry(wr_thread, rd_addr);
          wdata = new_data;
        end
        default: begin
          we = 1'b0;
        end
      endcase
    end
  end

  // Dropped-write indicator, one cycle after the rejected strobe.
  always_ff @(posedge clk) begin
    if (rst) wr_drop <= 1'b0;
    else     wr_drop <= wr_en && !ready;
  end

  // Array write; block RAM carries no reset, the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  genvar p;
  generate
    for (p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [IW-1:0]   ridx;
      logic [XLEN-1:0] rnext;
      logic [XLEN-1:0] q;

      assign ra   = rs_addr[p*AW +: AW];
      assign ridx = entry(rs_thread, ra);

      // Read value: x0 forced to zero, same-cycle write forwarded, else array.
      always_comb begin
        rnext = mem[ridx];
        if (ra == '0)                   rnext = '0;
        else if (we && (waddr == ridx)) rnext = wdata;
      end

      // Registered read data, held while the port is not enabled.
      always_ff @(posedge clk) begin
        if (rst)            q <= '0;
        else if (rs_en[p])  q <= rnext;
      end

      assign rs_data[p*XLEN +: XLEN] = q;
    end
  endgenerate

endmodule

// File: tb/tb_mt_register_file.sv
// Self-checking bench for mt_register_file: directed steps from the test
// plan followed by randomized traffic, all checked against a per-thread
// array model that follows the clear/write/read rules cycle by cycle.
module tb_mt_register_file;

  localparam int NT = 4;
  localparam int NR = 32;
  localparam int XL = 32;
  localparam int NP = 2;
  localparam int TW = 2;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [TW-1:0]     wr_thread = '0;
  logic [AW-1:0]     rd_addr = '0;
  logic [XL-1:0]     new_data = '0;
  logic [TW-1:0]     rs_thread = '0;
  logic [NP*AW-1:0]  rs_addr = '0;
  logic [NP-1:0]     rs_en = '0;
  logic [NP*XL-1:0]  rs_data;
  logic              clear_req = 1'b0;
  logic [TW-1:0]     clear_thread = '0;
  logic              ready;
  logic              wr_drop;

  always #5 clk = ~clk;

  mt_register_file #(
    .NUM_THREADS(NT), .NUM_REGS(NR), .XLEN(XL), .NUM_READ_PORTS(NP)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_thread(wr_thread), .rd_addr(rd_addr), .new_data(new_data),
    .rs_thread(rs_thread), .rs_addr(rs_addr), .rs_en(rs_en), .rs_data(rs_data),
    .clear_req(clear_req), .clear_thread(clear_thread),
    .ready(ready), .wr_drop(wr_drop)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [XL-1:0] m [NT][NR];
  bit            v [NT][NR];     // entry holds a defined value
  int            busy;           // cycles of ready=0 still ahead
  bit            in_init;        // the pending clear covers the whole array
  int            ct;             // thread being flushed
  logic          exp_drop;
  logic [XL-1:0] exp_rs [NP];
  bit            exp_known [NP];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] port(input int p);
    return rs_data[p*XL +: XL];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en     = 1'b0;
    rs_en     = '0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input int t, input int a, input logic [XL-1:0] d);
    wr_en     = 1'b1;
    wr_thread = TW'(t);
    rd_addr   = AW'(a);
    new_data  = d;
  endtask

  task automatic rd(input int p, input int a);
    rs_addr[p*AW +: AW] = AW'(a);
    rs_en[p]            = 1'b1;
  endtask

  // Advance one clock: update the model from the inputs present at the
  // edge, then compare every observable output shortly after the edge.
  task automatic step();
    int t, a, e;
    if (rst) begin
      busy    = NT * NR;
      in_init = 1'b1;
      exp_drop = 1'b0;
      for (int p = 0; p < NP; p++) begin
        exp_rs[p]    = '0;
        exp_known[p] = 1'b1;
      end
      for (int i = 0; i < NT; i++)
        for (int j = 0; j < NR; j++) v[i][j] = 1'b0;
    end else begin
      exp_drop = wr_en && (busy != 0);
      if (busy != 0) begin
        if (in_init) begin
          e = NT * NR - busy;
          m[e / NR][e % NR] = '0;
          v[e / NR][e % NR] = 1'b1;
        end else begin
          m[ct][NR - busy] = '0;
          v[ct][NR - busy] = 1'b1;
        end
      end else if (wr_en && rd_addr != 0) begin
        m[wr_thread][rd_addr] = new_data;
        v[wr_thread][rd_addr] = 1'b1;
      end
      t = int'(rs_thread);
      for (int p = 0; p < NP; p++) begin
        if (rs_en[p]) begin
          a = int'(rs_addr[p*AW +: AW]);
          if (a == 0) begin
            exp_rs[p]    = '0;
            exp_known[p] = 1'b1;
          end else begin
            exp_rs[p]    = m[t][a];
            exp_known[p] = v[t][a];
          end
        end
      end
      if (busy != 0) begin
        busy--;
        if (busy == 0) in_init = 1'b0;
      end else if (clear_req) begin
        busy = NR;
        ct   = int'(clear_thread);
      end
    end
    @(posedge clk);
    #1;
    chk("ready", XL'(ready), XL'(busy == 0));
    chk("wr_drop", XL'(wr_drop), XL'(exp_drop));
    for (int p = 0; p < NP; p++)
      if (exp_known[p]) chk($sformatf("rs_data%0d", p), port(p), exp_rs[p]);
  endtask

  // Count cycles with ready low, bounded so a stuck engine cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    while (ready === 1'b0 && n < 1000) begin
      n++;
      step();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bit saw_drop;

    // Reset for 3 cycles, then measure the init-clear window.
    rst = 1'b1;
    idle();
    repeat (3) step();
    rst = 1'b0;
    count_busy(n);
    chk("init_ready_low_cycles", XL'(n), XL'(NT * NR));

    // Freshly cleared entry reads zero.
    rs_thread = 2'd2;
    rd(0, 5);
    step();
    chk("t2x5_after_init", port(0), 32'h0);
    idle();

    // Plain write, then read from the owning and a different thread.
    wr(1, 7, 32'hDEADBEEF);
    step();
    idle();
    rs_thread = 2'd1;
    rd(0, 7);
    step();
    chk("t1x7", port(0), 32'hDEADBEEF);
    rs_thread = 2'd0;
    rd(1, 7);
    rs_en[0] = 1'b0;
    step();
    chk("t0x7", port(1), 32'h0);
    chk("t1x7_held", port(0), 32'hDEADBEEF);
    idle();

    // Same-cycle write and read of the same entry on both ports.
    wr(3, 9, 32'h12345678);
    rs_thread = 2'd3;
    rd(0, 9);
    rd(1, 9);
    step();
    chk("bypass_p0", port(0), 32'h12345678);
    chk("bypass_p1", port(1), 32'h12345678);
    idle();

    // x0 write is ignored without a drop pulse.
    wr(0, 0, 32'hFFFFFFFF);
    step();
    chk("x0_wr_drop", XL'(wr_drop), 32'h0);
    idle();
    rs_thread = 2'd0;
    rd(0, 0);
    step();
    chk("x0_read", port(0), 32'h0);
    idle();

    // Fill thread 2, then flush it.
    for (int r = 1; r < NR; r++) begin
      wr(2, r, 32'hA5000000 | XL'(r));
      step();
    end
    idle();
    clear_thread = 2'd2;
    clear_req    = 1'b1;
    step();
    clear_req = 1'b0;
    n = 0;
    saw_drop = 1'b0;
    while (ready === 1'b0 && n < 1000) begin
      wr_en     = (n == 5);
      wr_thread = 2'd1;
      rd_addr   = 5'd7;
      new_data  = 32'h0BADF00D;
      step();
      if (n == 5) saw_drop = wr_drop;
      n++;
    end
    wr_en = 1'b0;
    chk("thread_clear_cycles", XL'(n), XL'(NR));
    chk("drop_during_clear", XL'(saw_drop), 32'h1);
    rs_thread = 2'd2;
    for (int r = 1; r < NR; r++) begin
      rd(0, r);
      rd(1, NR - r);
      step();
      chk($sformatf("t2x%0d_cleared", r), port(0), 32'h0);
    end
    idle();
    rs_thread = 2'd1;
    rd(0, 7);
    step();
    chk("t1x7_intact", port(0), 32'hDEADBEEF);
    idle();

    // Reset in the middle of the init sweep restarts it from entry 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    chk("restart_ready_low_cycles", XL'(n), XL'(NT * NR));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 1499) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_thread = TW'($urandom_range(0, NT - 1));
      rd_addr   = AW'($urandom_range(0, NR - 1));
      new_data  = $urandom;
      rs_thread = TW'($urandom_range(0, NT - 1));
      rs_en     = NP'($urandom_range(0, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          rs_thread = wr_thread;
          rs_addr[p*AW +: AW] = rd_addr;
        end else begin
          rs_addr[p*AW +: AW] = AW'($urandom_range(0, NR - 1));
        end
      end
      clear_req    = ($urandom_range(0, 199) == 0);
      clear_thread = TW'($urandom_range(0, NT - 1));
      step();
    end
    rst = 1'b0;
    idle();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mt_register_file.md
Name: mt_register_file

Overview:
Parametrised multithreaded integer register file for the barrel-threaded pipeline. It holds NUM_THREADS banks of NUM_REGS x XLEN in one block-RAM array, with one write port and NUM_READ_PORTS registered read ports. It adds hardware x0 handling and a write-to-read bypass. Because block RAM has no reset, a counter-driven clear engine zeroes the array after reset and can flush a single thread on request. It sits between decode/issue (reads) and writeback (writes).

Parameters:
NUM_THREADS, 4, number of hardware threads (power of 2, >=1)
NUM_REGS, 32, architectural registers per thread (power of 2)
XLEN, 32, data width
NUM_READ_PORTS, 2, number of independent read ports
TW, derived = max(1,$clog2(NUM_THREADS)), thread id width
AW, derived = $clog2(NUM_REGS), register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  writeback write strobe
wr_thread  in  TW  thread of write
rd_addr  in  AW  destination register
new_data  in  XLEN  write data
rs_thread  in  TW  thread for all read ports this cycle
rs_addr  in  NUM_READ_PORTS*AW  source addresses, port p at [p*AW +: AW]
rs_en  in  NUM_READ_PORTS  per-port read enable
rs_data  out  NUM_READ_PORTS*XLEN  registered read data, port p at [p*XLEN +: XLEN]
clear_req  in  1  request flush of one thread
clear_thread  in  TW  thread to flush
ready  out  1  1 = clear engine idle, external writes accepted
wr_drop  out  1  one-cycle pulse: external write discarded

Behaviour:
- Entry index = {thread, addr}; the array holds NUM_THREADS*NUM_REGS entries. The array is not reset.
- FSM states: INIT_CLEAR, READY, THREAD_CLEAR. A counter cnt spans TW+AW bits.
- Reset (rst=1 at a clock edge): state=INIT_CLEAR, cnt=0, ready=0, wr_drop=0, all rs_data=0. Reset asserted mid-clear restarts the clear from entry 0.
- INIT_CLEAR: each cycle writes 0 to entry cnt, then cnt++. After writing entry NUM_THREADS*NUM_REGS-1, move to READY. ready rises in the cycle after the last clear write, so it is low for exactly NUM_THREADS*NUM_REGS cycles after reset deasserts.
- READY: if clear_req=1, latch clear_thread, set cnt=0, and go to THREAD_CLEAR; ready falls the next cycle.
- THREAD_CLEAR: writes 0 to {latched thread, cnt[AW-1:0]}, one per cycle, for NUM_REGS cycles, then returns to READY.
- clear_req is ignored outside READY.
- Write port arbitration:
  - The clear engine owns the write port whenever ready=0.
  - External wr_en=1 while ready=0 is discarded; wr_drop=1 in the following cycle.
  - In READY, wr_en=1 with rd_addr=0 is discarded silently (no wr_drop).
- Reads:
  - 1-cycle latency. rs_data[p] updates at the edge after rs_en[p]=1 and holds its value while rs_en[p]=0.
  - rs_addr[p]=0 returns 0 regardless of array contents.
  - Bypass: if the effective write (external or clear) in the same cycle targets the same {rs_thread, rs_addr[p]}, rs_data[p] returns the written value, not the old one.
  - Reads are serviced in every state. Data from not-yet-cleared entries is undefined only during INIT_CLEAR.
  - All ports may read the same entry simultaneously. Each port uses its own rs_addr[p] (no shared address).
- A read and a write of different entries in the same cycle are independent.

Test Plan:
- Reset, hold rst 3 cycles, release -> ready=0 for exactly 128 cycles (defaults), then 1; read t2/x5 -> rs_data[0]=0 one cycle later.
- READY: write t1/x7=0xDEADBEEF; next cycle read t1/x7 on port0 and t0/x7 on port1 -> 0xDEADBEEF and 0x00000000.
- Same-cycle write t3/x9=0x12345678 and read t3/x9 on both ports -> both ports return 0x12345678 next cycle.
- Write t0/x0=0xFFFFFFFF then read t0/x0 -> 0; wr_drop stays 0.
- Fill t2/x1..x31 with nonzero values; pulse clear_req with clear_thread=2 -> ready low 32 cycles; a write during that window gives wr_drop=1; afterwards t2 regs read 0 and t1 data is intact.
- Assert rst at cycle 50 of INIT_CLEAR -> clear restarts, ready stays low 128 cycles after release.
